// File: rtl/frame_scanout.sv
// frame_scanout: read side of the tracer's double-buffered 128x64 framebuffer.
// Generates VGA timing, fetches upscaled pixels centred on screen and swaps buffers at vblank.
module frame_scanout #(
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33,
    parameter logic [11:0] BORDER_RGB = 12'h000,
    parameter int          H_VISIBLE  = 640,
    parameter int          V_VISIBLE  = 480,
    parameter int          IMG_SHIFT  = 2
) (
    input  logic        tracer_clk,
    input  logic        rst,
    output logic [6:0]  rd_col,
    output logic [5:0]  rd_row,
    output logic        rd_buf,
    input  logic [11:0] rd_data,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        vblank,
    output logic        frame_start
);
    localparam int CW      = 11;
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int IMG_W   = 128 << IMG_SHIFT;
    localparam int IMG_H   = 64 << IMG_SHIFT;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] H_WIN_LO = CW'((H_VISIBLE - IMG_W) / 2);
    localparam logic [CW-1:0] H_WIN_HI = CW'((H_VISIBLE - IMG_W) / 2 + IMG_W);
    localparam logic [CW-1:0] V_WIN_LO = CW'((V_VISIBLE - IMG_H) / 2);
    localparam logic [CW-1:0] V_WIN_HI = CW'((V_VISIBLE - IMG_H) / 2 + IMG_H);
    localparam logic [CW-1:0] HS_LO    = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_HI    = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_LO    = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_HI    = CW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CW-1:0] h_cnt_p0, v_cnt_p0;
    logic [CW-1:0] h_off_p0, v_off_p0;
    logic          win_p0, vis_p0, swap_p0;
    logic          win_p1, vis_p1, hsync_p1, vsync_p1, vblank_p1, fs_p1;
    logic          win_p2, vis_p2;

    // stage 0: raster counters
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + ONE;
        end else begin
            h_cnt_p0 <= h_cnt_p0 + ONE;
        end
    end

    always_comb begin
        win_p0   = (h_cnt_p0 >= H_WIN_LO) && (h_cnt_p0 < H_WIN_HI) &&
                   (v_cnt_p0 >= V_WIN_LO) && (v_cnt_p0 < V_WIN_HI);
        vis_p0   = (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
        h_off_p0 = h_cnt_p0 - H_WIN_LO;
        v_off_p0 = v_cnt_p0 - V_WIN_LO;
        swap_p0  = (h_cnt_p0 == '0) && (v_cnt_p0 == V_VIS) && swap_req;
    end

    // stage 1: framebuffer address plus delayed raster flags
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            rd_col    <= '0;
            rd_row    <= '0;
            win_p1    <= 1'b0;
            vis_p1    <= 1'b0;
            hsync_p1  <= 1'b1;
            vsync_p1  <= 1'b1;
            vblank_p1 <= 1'b0;
            fs_p1     <= 1'b0;
        end else begin
            rd_col    <= win_p0 ? 7'(h_off_p0 >> IMG_SHIFT) : '0;
            rd_row    <= win_p0 ? 6'(v_off_p0 >> IMG_SHIFT) : '0;
            win_p1    <= win_p0;
            vis_p1    <= vis_p0;
            hsync_p1  <= !((h_cnt_p0 >= HS_LO) && (h_cnt_p0 < HS_HI));
            vsync_p1  <= !((v_cnt_p0 >= VS_LO) && (v_cnt_p0 < VS_HI));
            vblank_p1 <= (v_cnt_p0 >= V_VIS);
            fs_p1     <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
        end
    end

    // Swap is only honoured at the first pixel of vblank, so rd_buf never moves mid-image.
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            rd_buf   <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap_p0;
            if (swap_p0) begin
                rd_buf <= ~rd_buf;
            end
        end
    end

    // stage 2: sync pins and colour select aligned with the BRAM read data
    always_ff @(posedge tracer_clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            win_p2      <= 1'b0;
            vis_p2      <= 1'b0;
        end else begin
            hsync       <= hsync_p1;
            vsync       <= vsync_p1;
            vblank      <= vblank_p1;
            frame_start <= fs_p1;
            win_p2      <= win_p1;
            vis_p2      <= vis_p1;
        end
    end

    // rd_data is already the BRAM output register, so only the select is registered here.
    always_comb begin
        rgb = 12'h000;
        if (win_p2) begin
            rgb = rd_data;
        end else if (vis_p2) begin
            rgb = BORDER_RGB;
        end
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Scoreboard bench for frame_scanout: a compact-geometry instance against a raster model,
// plus a default-geometry instance for the first lines of VGA timing.
module tb_frame_scanout;
    localparam int HV = 136, HF = 4, HS = 8, HB = 4;
    localparam int VV = 68,  VF = 2, VS = 2, VB = 2;
    localparam int SH = 0;
    localparam logic [11:0] BORDER = 12'h5C3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int H0 = (HV - (128 << SH)) / 2;
    localparam int V0 = (VV - (64 << SH)) / 2;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst, swap_req;
    logic [6:0] rd_col0, rd_col1;
    logic [5:0] rd_row0, rd_row1;
    logic rd_buf0, rd_buf1, swap_ack0, swap_ack1;
    logic hsync0, hsync1, vsync0, vsync1, vblank0, vblank1, fs0, fs1;
    logic [11:0] rd_data0, rd_data1, rgb0, rgb1;

    logic [11:0] mem [0:1][0:63][0:127];
    exp_t aq[$];
    exp_t pq[$];
    int cyc = 0;
    int start0 = -1;
    int n_checks = 0;
    int n_fail = 0;
    int ack_seen = 0;

    always #20 clk = ~clk;

    frame_scanout #(
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BORDER_RGB(BORDER), .H_VISIBLE(HV), .V_VISIBLE(VV), .IMG_SHIFT(SH)
    ) dut (
        .tracer_clk(clk), .rst(rst), .rd_col(rd_col0), .rd_row(rd_row0), .rd_buf(rd_buf0),
        .rd_data(rd_data0), .swap_req(swap_req), .swap_ack(swap_ack0), .hsync(hsync0),
        .vsync(vsync0), .rgb(rgb0), .vblank(vblank0), .frame_start(fs0)
    );

    frame_scanout dut_vga (
        .tracer_clk(clk), .rst(rst), .rd_col(rd_col1), .rd_row(rd_row1), .rd_buf(rd_buf1),
        .rd_data(rd_data1), .swap_req(swap_req), .swap_ack(swap_ack1), .hsync(hsync1),
        .vsync(vsync1), .rgb(rgb1), .vblank(vblank1), .frame_start(fs1)
    );

    // Synchronous-read BRAM models.
    always @(posedge clk) begin
        rd_data0 <= mem[rd_buf0][rd_row0][rd_col0];
        rd_data1 <= {rd_col1[3:0], rd_row1[3:0], 4'hA};
    end

    task automatic check(input string name, input int at, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, at, act, exp);
        end
    endtask

    // Monitor: pops whatever expectation is due this cycle and compares.
    always @(negedge clk) begin
        exp_t e;
        while (aq.size() > 0 && aq[0].due < cyc) begin
            e = aq.pop_front();
            check("addr_stale", e.due, 16'hFFFF, e.val);
        end
        while (pq.size() > 0 && pq[0].due < cyc) begin
            e = pq.pop_front();
            check("pins_stale", e.due, 16'hFFFF, e.val);
        end
        if (aq.size() > 0 && aq[0].due == cyc) begin
            e = aq.pop_front();
            check("buf_ack_row_col", cyc, {1'b0, rd_buf0, swap_ack0, rd_row0, rd_col0}, e.val);
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            e = pq.pop_front();
            check("hs_vs_vb_fs_rgb", cyc, {hsync0, vsync0, vblank0, fs0, rgb0}, e.val);
        end
        if (swap_ack0 === 1'b1) ack_seen++;
    end

    // Default-geometry instance: first lines after reset.
    initial begin
        int m, hs_low;
        bit addr_seen;
        hs_low = 0;
        addr_seen = 0;
        wait (start0 >= 0);
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            m = cyc - start0;
            if (m >= 2 && m < 802 && hsync1 == 1'b0) hs_low++;
            if (m >= 0 && (rd_col1 != 7'd0 || rd_row1 != 6'd0)) addr_seen = 1;
            case (m)
                0:    begin
                          check("vga_reset_ctl", m, 16'({hsync1, vsync1, vblank1, fs1, swap_ack1, rd_buf1}), 16'b110000);
                          check("vga_reset_rgb", m, 16'(rgb1), 16'h000);
                      end
                1:    check("vga_c1_hs_fs", m, 16'({hsync1, fs1}), 16'b10);
                2:    check("vga_fs_pulse", m, 16'(fs1), 16'd1);
                3:    check("vga_fs_end", m, 16'(fs1), 16'd0);
                100:  check("vga_border", m, 16'(rgb1), 16'h000);
                657:  check("vga_hs_pre", m, 16'(hsync1), 16'd1);
                658:  check("vga_hs_fall", m, 16'(hsync1), 16'd0);
                753:  check("vga_hs_last", m, 16'(hsync1), 16'd0);
                754:  check("vga_hs_rise", m, 16'(hsync1), 16'd1);
                802:  check("vga_hs_width", m, 16'(hs_low), 16'd96);
                1000: check("vga_vs_vb", m, 16'({vsync1, vblank1}), 16'b10);
                1458: check("vga_hs_period", m, 16'(hsync1), 16'd0);
                1554: check("vga_hs_rise2", m, 16'(hsync1), 16'd1);
                1600: check("vga_addr_outside", m, 16'(addr_seen), 16'd0);
                default: ;
            endcase
        end
    end

    // Stimulus and reference model: raster position is derived from cycles since reset.
    initial begin
        int n, h, v, sess, raise_n, drop_n, rst_n, end_n, col, row;
        bit do_rst, req, ack, win, vis;
        logic mbuf;
        logic [11:0] px;
        rst = 1'b1;
        swap_req = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 128; c++)
                    mem[b][r][c] = 12'($urandom);
        raise_n = $urandom_range(5, 20) * HT + $urandom_range(0, HT - 1);
        drop_n  = 3 * FR + $urandom_range(2, 30) * HT + $urandom_range(0, HT - 1);
        rst_n   = 3 * FR + 40 * HT + 100;
        end_n   = FR + 70 * HT;
        sess = -1;
        n = 0;
        mbuf = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        for (int it = 0; it < 100000; it++) begin
            h = n % HT;
            v = (n / HT) % VT;
            if (sess == 1 && n == end_n) break;
            if (sess < 0) begin
                do_rst = 1;
                req = 0;
            end else if (sess == 0) begin
                do_rst = (n == rst_n);
                req = (n >= raise_n && n < drop_n);
            end else begin
                do_rst = 0;
                if (n >= 10 * HT && n < 60 * HT) req = 1'($urandom_range(0, 1));
                else req = (n >= raise_n && n < drop_n);
            end
            rst = do_rst;
            swap_req = req;
            if (do_rst) begin
                while (aq.size() > 0 && aq[$].due > cyc) void'(aq.pop_back());
                while (pq.size() > 0 && pq[$].due > cyc) void'(pq.pop_back());
                aq.push_back('{cyc + 1, 16'h0000});
                pq.push_back('{cyc + 1, {4'b1100, 12'h000}});
                pq.push_back('{cyc + 2, {4'b1100, 12'h000}});
                mbuf = 1'b0;
                n = 0;
                if (sess < 0 && it == 2) begin
                    sess = 0;
                    start0 = cyc + 1;
                end else if (sess == 0) begin
                    sess = 1;
                    raise_n = $urandom_range(VV + 1, VV + 5) * HT + $urandom_range(0, HT - 1);
                    drop_n  = FR + $urandom_range(5, 30) * HT + $urandom_range(0, HT - 1);
                end
            end else begin
                ack = (h == 0 && v == VV && req);
                if (ack) mbuf = ~mbuf;
                win = (h >= H0 && h < H0 + (128 << SH) && v >= V0 && v < V0 + (64 << SH));
                vis = (h < HV && v < VV);
                col = win ? (h - H0) >> SH : 0;
                row = win ? (v - V0) >> SH : 0;
                px = win ? mem[mbuf][row][col] : (vis ? BORDER : 12'h000);
                aq.push_back('{cyc + 1, {1'b0, mbuf, ack, 6'(row), 7'(col)}});
                pq.push_back('{cyc + 2, {!(h >= HV + HF && h < HV + HF + HS),
                                         !(v >= VV + VF && v < VV + VF + VS),
                                         (v >= VV), (h == 0 && v == 0), px}});
                n++;
            end
            @(posedge clk);
            cyc++;
            #1;
        end
        rst = 1'b0;
        swap_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("swap_ack_count", cyc, 16'(ack_seen), 16'd3);
        check("scoreboard_drained", cyc, 16'(aq.size() + pq.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 90000);
        $display("FAIL timeout: bench did not complete, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
